// File: rtl/mtm_alu_ctrl.sv
// mtm_alu_ctrl: sequences requests from the deserializer through the ALU core
// (or straight to an error response) and on to the serializer. A one-entry
// pending buffer holds a request that arrives while a transaction is in flight.
module mtm_alu_ctrl #(
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  input  logic [31:0] req_A,
  input  logic [31:0] req_B,
  input  logic [2:0]  req_op,
  input  logic [5:0]  req_err,
  output logic [31:0] core_A,
  output logic [31:0] core_B,
  output logic [2:0]  core_op,
  output logic        core_start,
  input  logic [31:0] core_C,
  input  logic [3:0]  core_flags,
  output logic        ser_start,
  output logic        ser_is_err,
  output logic [31:0] ser_C,
  output logic [7:0]  ser_ctl,
  input  logic        ser_done,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SEND_RES,
    SEND_ERR,
    WAIT_SER
  } state_t;

  localparam logic [3:0]  LAT_LAST = 4'(CORE_LAT);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;

  logic        pend_vld;
  logic [31:0] pend_a, pend_b;
  logic [2:0]  pend_op;
  logic [1:0]  pend_err;

  logic [3:0]  lat_cnt;
  logic [15:0] to_cnt;

  logic        src_vld;
  logic [31:0] src_a, src_b;
  logic [2:0]  src_op;
  logic [1:0]  src_err;
  logic [5:0]  src_code;
  logic        src_bad;
  logic        accept;
  logic        capture;
  logic        ser_to;
  logic        unused_err_bits;

  // Only the DATA and CRC flag bits steer the response; the rest are ignored.
  assign unused_err_bits = ^req_err[3:0];

  // Highest-priority error code for a request, zero when the request is good.
  function automatic logic [5:0] err_code(input logic [1:0] err, input logic [2:0] op);
    if (err[1])
      return 6'b100100;
    else if (err[0])
      return 6'b010010;
    else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101}))
      return 6'b001001;
    else
      return '0;
  endfunction

  // Request source in IDLE: the pending entry takes precedence over a new pulse.
  always_comb begin
    src_vld = pend_vld | req_vld;
    src_a   = req_A;
    src_b   = req_B;
    src_op  = req_op;
    src_err = req_err[5:4];
    if (pend_vld) begin
      src_a   = pend_a;
      src_b   = pend_b;
      src_op  = pend_op;
      src_err = pend_err;
    end
  end

  assign src_code   = err_code(src_err, src_op);
  assign src_bad    = |src_code;
  assign accept     = (state == IDLE) && src_vld;
  assign capture    = (state == EXEC) && (lat_cnt == LAT_LAST);
  assign ser_to     = (state == WAIT_SER) && !ser_done && (to_cnt == TO_LAST);

  assign core_start = (state == EXEC) && (lat_cnt == '0);
  assign ser_start  = (state == SEND_RES) || (state == SEND_ERR);
  assign busy       = (state != IDLE) || pend_vld;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; ser_done takes priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (src_vld) state_nxt = src_bad ? SEND_ERR : EXEC;
      EXEC:     if (capture) state_nxt = SEND_RES;
      SEND_RES: state_nxt = WAIT_SER;
      SEND_ERR: state_nxt = WAIT_SER;
      WAIT_SER: if (ser_done || ser_to) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Core latency and serializer timeout counters, plus the timeout pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt     <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      lat_cnt     <= ((state == EXEC) && !capture) ? lat_cnt + 4'd1 : '0;
      to_cnt      <= (state == WAIT_SER) ? to_cnt + 16'd1 : '0;
      timeout_err <= ser_to;
    end
  end

  // Core operand registers, loaded only when a good request is launched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_A  <= '0;
      core_B  <= '0;
      core_op <= '0;
    end else if (accept && !src_bad) begin
      core_A  <= src_a;
      core_B  <= src_b;
      core_op <= src_op;
    end
  end

  // Serializer payload: result capture or error control byte with even parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_C      <= '0;
      ser_ctl    <= '0;
      ser_is_err <= 1'b0;
    end else if (accept && src_bad) begin
      ser_is_err <= 1'b1;
      ser_ctl    <= {1'b1, src_code, ^{1'b1, src_code}};
    end else if (capture) begin
      ser_is_err <= 1'b0;
      ser_C      <= core_C;
      ser_ctl    <= {1'b0, core_flags, 3'b000};
    end
  end

  // Pending buffer: serving it in IDLE frees the slot on the same edge a new
  // pulse refills it, so only overlap with a full slot outside IDLE is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld <= 1'b0;
      pend_a   <= '0;
      pend_b   <= '0;
      pend_op  <= '0;
      pend_err <= '0;
      drop_cnt <= '0;
    end else if (req_vld && (pend_vld || (state != IDLE))) begin
      if ((state == IDLE) || !pend_vld) begin
        pend_vld <= 1'b1;
        pend_a   <= req_A;
        pend_b   <= req_B;
        pend_op  <= req_op;
        pend_err <= req_err[5:4];
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if ((state == IDLE) && pend_vld) begin
      pend_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Testbench for mtm_alu_ctrl: behavioural ALU core, scoreboard of expected
// serializer frames, and per-scenario tasks with inline checks.
module tb_mtm_alu_ctrl;

  localparam int unsigned LAT = 1;
  localparam int unsigned TO  = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic [31:0] req_A, req_B;
  logic [2:0]  req_op;
  logic [5:0]  req_err;
  logic [31:0] core_A, core_B;
  logic [2:0]  core_op;
  logic        core_start;
  logic [31:0] core_C;
  logic [3:0]  core_flags;
  logic        ser_start, ser_is_err;
  logic [31:0] ser_C;
  logic [7:0]  ser_ctl;
  logic        ser_done;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        timeout_err;

  typedef struct {
    logic        is_err;
    logic [31:0] c;
    logic [7:0]  ctl;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          ck      = 0;
  logic [31:0] last_c  = '0;
  logic [35:0] cm;

  mtm_alu_ctrl #(.CORE_LAT(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_A(req_A), .req_B(req_B), .req_op(req_op), .req_err(req_err),
    .core_A(core_A), .core_B(core_B), .core_op(core_op), .core_start(core_start),
    .core_C(core_C), .core_flags(core_flags),
    .ser_start(ser_start), .ser_is_err(ser_is_err), .ser_C(ser_C), .ser_ctl(ser_ctl),
    .ser_done(ser_done), .busy(busy), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference ALU: {carry, overflow, zero, negative, result}.
  function automatic logic [35:0] core_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    logic [32:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      3'b000: r = {1'b0, a & b};
      3'b001: r = {1'b0, a | b};
      3'b100: begin r = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b101: begin r = {1'b0, a} - {1'b0, b}; v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: r = '0;
    endcase
    return {r[32], v, (r[31:0] == 32'd0), r[31], r[31:0]};
  endfunction

  // Behavioural core: result valid from the core_start cycle for LAT cycles,
  // garbage otherwise so a mistimed capture is visible.
  initial begin
    core_C     = 32'hDEADBEEF;
    core_flags = 4'hF;
  end
  always @(negedge clk) begin
    if (core_start === 1'b1) begin
      cm         = core_model(core_A, core_B, core_op);
      core_C     = cm[31:0];
      core_flags = cm[35:32];
      ck         = LAT + 1;
    end else if (ck > 0) begin
      ck--;
      if (ck == 0) begin
        core_C     = 32'hDEADBEEF;
        core_flags = 4'hF;
      end
    end
  end

  // Scoreboard: every ser_start pops one expected frame.
  always @(negedge clk) begin
    if (rst === 1'b1 && ser_start === 1'b1) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ser_start cyc=%0d is_err=%b C=%h ctl=%b", cyc, ser_is_err, ser_C, ser_ctl);
      end else begin
        mon_e = sbq.pop_front();
        if (ser_is_err !== mon_e.is_err || ser_C !== mon_e.c || ser_ctl !== mon_e.ctl || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL ser_frame got is_err=%b C=%h ctl=%b cyc=%0d expected is_err=%b C=%h ctl=%b cyc=%0d",
                   ser_is_err, ser_C, ser_ctl, cyc, mon_e.is_err, mon_e.c, mon_e.ctl, mon_e.cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive a one-cycle request; must be called on a negedge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [5:0] err);
    req_A = a; req_B = b; req_op = op; req_err = err; req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic pulse_done(input int t);
    wait_cyc(t);
    ser_done = 1'b1;
    wait_cyc(t + 1);
    ser_done = 1'b0;
  endtask

  task automatic push_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input int c);
    logic [35:0] m;
    m = core_model(a, b, op);
    sbq.push_back('{is_err: 1'b0, c: m[31:0], ctl: {1'b0, m[35:32], 3'b000}, cyc: c});
    last_c = m[31:0];
  endtask

  task automatic test_reset();
    rst = 1'b0; req_vld = 1'b0; req_A = '0; req_B = '0; req_op = '0; req_err = '0; ser_done = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({core_A, core_B, core_op, core_start, ser_start, ser_is_err, ser_C, ser_ctl, busy, drop_cnt, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got A=%h B=%h op=%b cs=%b ss=%b ie=%b C=%h ctl=%b busy=%b drop=%0d to=%b expected all 0",
               core_A, core_B, core_op, core_start, ser_start, ser_is_err, ser_C, ser_ctl, busy, drop_cnt, timeout_err);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good();
    int c0;
    c0 = cyc;
    sbq.push_back('{is_err: 1'b0, c: 32'd8, ctl: 8'h00, cyc: c0 + 3});
    last_c = 32'd8;
    send(32'd5, 32'd3, 3'b100, 6'b0);
    n_tests++;
    if (core_start !== 1'b1 || core_A !== 32'd5 || core_B !== 32'd3 || core_op !== 3'b100) begin
      n_fail++;
      $display("FAIL good_launch got cs=%b A=%h B=%h op=%b expected cs=1 A=5 B=3 op=100", core_start, core_A, core_B, core_op);
    end
    wait_cyc(c0 + 2);
    n_tests++;
    if (core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL good_start_width got core_start=%b expected 0", core_start);
    end
    wait_cyc(c0 + 10);
    n_tests++;
    if (ser_start !== 1'b0 || ser_is_err !== 1'b0 || ser_C !== 32'd8 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL good_wait_hold got ss=%b ie=%b C=%h busy=%b expected 0 0 8 1", ser_start, ser_is_err, ser_C, busy);
    end
    pulse_done(c0 + 20);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL good_busy_after_done got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_err(input logic [31:0] a, input logic [2:0] op, input logic [5:0] err,
                          input logic [7:0] ctl);
    int c0;
    c0 = cyc;
    sbq.push_back('{is_err: 1'b1, c: last_c, ctl: ctl, cyc: c0 + 1});
    send(a, ~a, op, err);
    n_tests++;
    if (core_start !== 1'b0 || core_A !== 32'd5 || core_B !== 32'd3 || core_op !== 3'b100) begin
      n_fail++;
      $display("FAIL err_core_untouched got cs=%b A=%h B=%h op=%b expected cs=0 A=5 B=3 op=100",
               core_start, core_A, core_B, core_op);
    end
    pulse_done(c0 + 4);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_busy_after_done got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_pending();
    int c0;
    c0 = cyc;
    push_res(32'd10, 32'd20, 3'b101, c0 + 3);
    send(32'd10, 32'd20, 3'b101, 6'b0);
    wait_cyc(c0 + 5);
    push_res(32'd100, 32'd1, 3'b000, c0 + 14);
    req_A = 32'd100; req_B = 32'd1; req_op = 3'b000; req_err = '0; req_vld = 1'b1;
    wait_cyc(c0 + 6);
    req_A = 32'd200; req_B = 32'd2;
    wait_cyc(c0 + 7);
    req_A = 32'd300; req_B = 32'd3;
    wait_cyc(c0 + 8);
    req_vld = 1'b0;
    n_tests++;
    if (drop_cnt !== 8'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_drop got drop=%0d busy=%b expected drop=2 busy=1", drop_cnt, busy);
    end
    pulse_done(c0 + 10);
    n_tests++;
    if (core_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_idle_cycle got cs=%b busy=%b expected cs=0 busy=1", core_start, busy);
    end
    push_res(32'd7, 32'd9, 3'b001, c0 + 20);
    req_A = 32'd7; req_B = 32'd9; req_op = 3'b001; req_err = '0; req_vld = 1'b1;
    wait_cyc(c0 + 12);
    req_vld = 1'b0;
    n_tests++;
    if (core_start !== 1'b1 || core_A !== 32'd100 || core_B !== 32'd1 || core_op !== 3'b000) begin
      n_fail++;
      $display("FAIL pend_launch got cs=%b A=%h B=%h op=%b expected cs=1 A=64 B=1 op=000",
               core_start, core_A, core_B, core_op);
    end
    pulse_done(c0 + 16);
    wait_cyc(c0 + 18);
    n_tests++;
    if (core_start !== 1'b1 || core_A !== 32'd7 || core_op !== 3'b001) begin
      n_fail++;
      $display("FAIL pend_refill_launch got cs=%b A=%h op=%b expected cs=1 A=7 op=001", core_start, core_A, core_op);
    end
    pulse_done(c0 + 22);
    n_tests++;
    if (busy !== 1'b0 || drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL pend_end got busy=%b drop=%0d expected busy=0 drop=2", busy, drop_cnt);
    end
  endtask

  task automatic test_timeout();
    int c0, c1;
    c0 = cyc;
    push_res(32'd1, 32'd1, 3'b100, c0 + 3);
    send(32'd1, 32'd1, 3'b100, 6'b0);
    wait_cyc(c0 + 4 + TO - 1);
    n_tests++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_early got to=%b busy=%b expected to=0 busy=1", timeout_err, busy);
    end
    wait_cyc(c0 + 4 + TO);
    n_tests++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse got to=%b busy=%b expected to=1 busy=0", timeout_err, busy);
    end
    wait_cyc(c0 + 5 + TO);
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_width got to=%b expected 0", timeout_err);
    end
    c1 = cyc;
    push_res(32'd2, 32'd3, 3'b001, c1 + 3);
    send(32'd2, 32'd3, 3'b001, 6'b0);
    pulse_done(c1 + 4 + TO - 1);
    n_tests++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done_wins got to=%b busy=%b expected to=0 busy=0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    logic seen;
    c0 = cyc;
    send(32'd4, 32'd4, 3'b100, 6'b0);
    req_A = 32'd6; req_B = 32'd6; req_op = 3'b100; req_err = '0; req_vld = 1'b1;
    wait_cyc(c0 + 2);
    req_vld = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL rstmid_pre got busy=%b drop=%0d expected busy=1 drop=2", busy, drop_cnt);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({core_A, core_B, core_op, core_start, ser_start, ser_is_err, ser_C, ser_ctl, busy, drop_cnt, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got A=%h B=%h op=%b cs=%b ss=%b C=%h ctl=%b busy=%b drop=%0d expected all 0",
               core_A, core_B, core_op, core_start, ser_start, ser_C, ser_ctl, busy, drop_cnt);
    end
    wait_cyc(c0 + 4);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (core_start !== 1'b0 || ser_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet got activity=%b expected 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good();
    test_err(32'd77, 3'b100, 6'b110110, 8'b11001001);
    test_err(32'd1,  3'b011, 6'b000000, 8'b10010011);
    test_err(32'd9,  3'b111, 6'b010010, 8'b10100101);
    test_pending();
    test_timeout();
    test_reset_mid();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending frames expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
